// File: rtl/mem_inst_sequencer_pkg.sv
// Shared opcodes, instruction field positions and FSM encodings for the
// memory-interface instruction sequencer.
package mem_inst_sequencer_pkg;

  localparam logic [3:0] OP_READ  = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h5;
  localparam logic [3:0] OP_WFI   = 4'h6;
  localparam logic [3:0] OP_LOOP  = 4'h7;

  // Instruction word layout: {lanes[55:8], opcode[7:4], arg[3:0]}
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 4;
  localparam int ARG_MSB  = 3;
  localparam int ARG_LSB  = 0;
  localparam int LANE_LSB = 8;
  localparam int LANE_MSB = LANE_LSB + 3 * 16 - 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_RD     = 3'd3;
  localparam logic [2:0] ST_SH     = 3'd4;
  localparam logic [2:0] ST_WFI    = 3'd5;
  localparam logic [2:0] ST_LOOP   = 3'd6;

  function automatic logic is_known_opcode(input logic [3:0] opc);
    return (opc == OP_READ) || (opc == OP_SHIFT) ||
           (opc == OP_WFI)  || (opc == OP_LOOP);
  endfunction

endpackage

// File: rtl/mem_inst_sequencer_if.sv
// Control, ROM and read/shift command signals between the sequencer (master)
// and the accelerator control / ROM / datapath side (slave).
interface mem_inst_sequencer_if #(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_LANES  = 16,
  parameter int ITER_WIDTH = 16
);

  logic                    START;
  logic [ITER_WIDTH-1:0]   NUM_ITERATIONS;
  logic [ADDR_WIDTH-1:0]   ROM_ADDRESS;
  logic                    ROM_ENABLE;
  logic [INST_WIDTH-1:0]   ROM_DATA;
  logic                    RD_VALID;
  logic [3:0]              RD_MASK;
  logic                    RD_READY;
  logic                    SH_VALID;
  logic [3:0]              SH_AMOUNT;
  logic [NUM_LANES*3-1:0]  SH_LANES;
  logic                    SH_READY;
  logic                    COMPUTE_DONE;
  logic                    BUSY;
  logic                    DONE;
  logic [ITER_WIDTH-1:0]   ITER_COUNT;

  modport master (
    input  START, NUM_ITERATIONS, ROM_DATA, RD_READY, SH_READY, COMPUTE_DONE,
    output ROM_ADDRESS, ROM_ENABLE, RD_VALID, RD_MASK, SH_VALID, SH_AMOUNT,
           SH_LANES, BUSY, DONE, ITER_COUNT
  );

  modport slave (
    output START, NUM_ITERATIONS, ROM_DATA, RD_READY, SH_READY, COMPUTE_DONE,
    input  ROM_ADDRESS, ROM_ENABLE, RD_VALID, RD_MASK, SH_VALID, SH_AMOUNT,
           SH_LANES, BUSY, DONE, ITER_COUNT
  );

endinterface

// File: rtl/mem_inst_decode.sv
// Combinational split of an instruction word into opcode, argument and lane
// fields; is_valid flags opcodes the sequencer executes (others act as NOP).
module mem_inst_decode
  import mem_inst_sequencer_pkg::*;
#(
  parameter int INST_WIDTH = 56,
  parameter int NUM_LANES  = 16
) (
  input  logic [INST_WIDTH-1:0]  inst,
  output logic [3:0]             opcode,
  output logic [3:0]             arg,
  output logic [NUM_LANES*3-1:0] lanes,
  output logic                   is_valid
);

  assign opcode   = inst[OPC_MSB:OPC_LSB];
  assign arg      = inst[ARG_MSB:ARG_LSB];
  assign lanes    = inst[LANE_MSB:LANE_LSB];
  assign is_valid = is_known_opcode(inst[OPC_MSB:OPC_LSB]);

endmodule

// File: rtl/mem_inst_sequencer.sv
// Fetch/decode/issue FSM: READ and SHIFT commands with valid/ready handshakes,
// WFI stalls on COMPUTE_DONE, LOOP restarts from address 0 until the pass count.
module mem_inst_sequencer
  import mem_inst_sequencer_pkg::*;
#(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_LANES  = 16,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  mem_inst_sequencer_if.master  bus
);

  logic [2:0]             state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  pc_inc;
  logic [3:0]             arg_q;
  logic [NUM_LANES*3-1:0] lanes_q;
  logic [ITER_WIDTH-1:0]  iter_target;
  logic [ITER_WIDTH-1:0]  iter_count;
  logic [ITER_WIDTH-1:0]  iter_next;
  logic                   rd_valid_q;
  logic                   sh_valid_q;
  logic                   busy_q;
  logic                   done_q;

  logic [3:0]             dec_opcode;
  logic [3:0]             dec_arg;
  logic [NUM_LANES*3-1:0] dec_lanes;
  logic                   dec_valid;

  mem_inst_decode #(
    .INST_WIDTH (INST_WIDTH),
    .NUM_LANES  (NUM_LANES)
  ) u_decode (
    .inst     (bus.ROM_DATA),
    .opcode   (dec_opcode),
    .arg      (dec_arg),
    .lanes    (dec_lanes),
    .is_valid (dec_valid)
  );

  // PC wraps naturally at the top of the ROM
  assign pc_inc    = pc + ADDR_WIDTH'(1);
  assign iter_next = iter_count + ITER_WIDTH'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      pc          <= '0;
      arg_q       <= '0;
      lanes_q     <= '0;
      iter_target <= '0;
      iter_count  <= '0;
      rd_valid_q  <= 1'b0;
      sh_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            iter_target <= (bus.NUM_ITERATIONS == '0) ? ITER_WIDTH'(1)
                                                      : bus.NUM_ITERATIONS;
            iter_count  <= '0;
            pc          <= '0;
            busy_q      <= 1'b1;
            state       <= ST_FETCH;
          end
        end

        ST_FETCH: state <= ST_DECODE;

        ST_DECODE: begin
          // Payload is captured here and stays frozen until the next decode
          arg_q   <= dec_arg;
          lanes_q <= dec_lanes;
          if (!dec_valid) begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end else begin
            case (dec_opcode)
              OP_READ: begin
                rd_valid_q <= 1'b1;
                state      <= ST_RD;
              end
              OP_SHIFT: begin
                sh_valid_q <= 1'b1;
                state      <= ST_SH;
              end
              OP_WFI:  state <= ST_WFI;
              OP_LOOP: state <= ST_LOOP;
              default: begin
                pc    <= pc_inc;
                state <= ST_FETCH;
              end
            endcase
          end
        end

        ST_RD: begin
          if (bus.RD_READY) begin
            rd_valid_q <= 1'b0;
            pc         <= pc_inc;
            state      <= ST_FETCH;
          end
        end

        ST_SH: begin
          if (bus.SH_READY) begin
            sh_valid_q <= 1'b0;
            pc         <= pc_inc;
            state      <= ST_FETCH;
          end
        end

        ST_WFI: begin
          if (bus.COMPUTE_DONE) begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end
        end

        ST_LOOP: begin
          iter_count <= iter_next;
          if (iter_next == iter_target) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            pc    <= '0;
            state <= ST_FETCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ROM_ENABLE  = (state == ST_FETCH);
  assign bus.ROM_ADDRESS = pc;
  assign bus.RD_VALID    = rd_valid_q;
  assign bus.RD_MASK     = arg_q;
  assign bus.SH_VALID    = sh_valid_q;
  assign bus.SH_AMOUNT   = arg_q;
  assign bus.SH_LANES    = lanes_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.ITER_COUNT  = iter_count;

  a_cmd_exclusive: assert property (@(posedge CLK) disable iff (RESET)
    !(rd_valid_q && sh_valid_q));

  a_rd_hold: assert property (@(posedge CLK) disable iff (RESET)
    (rd_valid_q && !bus.RD_READY) |=> (rd_valid_q && $stable(arg_q)));

  a_sh_hold: assert property (@(posedge CLK) disable iff (RESET)
    (sh_valid_q && !bus.SH_READY) |=> (sh_valid_q && $stable(arg_q) && $stable(lanes_q)));

  a_done_not_busy: assert property (@(posedge CLK) disable iff (RESET)
    done_q |-> !busy_q);

endmodule

// File: tb/tb_mem_inst_sequencer.sv
// Directed bench for mem_inst_sequencer: single-instruction vector table plus
// hand-written multi-cycle sequences, checked against hand-computed values.
module tb_mem_inst_sequencer;

  localparam int IW = 56;
  localparam int AW = 6;
  localparam int NL = 16;
  localparam int TW = 16;
  localparam logic [IW-1:0] LOOP_WORD = 56'h70;
  localparam logic [IW-1:0] NOP_WORD  = 56'h10;

  logic CLK;
  logic RESET;

  mem_inst_sequencer_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .NUM_LANES(NL), .ITER_WIDTH(TW)) bus ();

  mem_inst_sequencer #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .NUM_LANES(NL), .ITER_WIDTH(TW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One-cycle registered ROM
  logic [IW-1:0] rom [64];
  always @(posedge CLK) if (bus.ROM_ENABLE) bus.ROM_DATA <= rom[bus.ROM_ADDRESS];

  int n_cmp = 0;
  int n_err = 0;

  int          f_rd_cyc, f_sh_cyc, done_cyc, done_cnt, rd_hs, sh_hs, both_cnt;
  logic [3:0]  f_rd_mask, f_sh_amt;
  logic [47:0] f_sh_lanes;

  typedef struct {
    logic [IW-1:0] inst;
    int            kind;     // 0 none, 1 read, 2 shift
    logic [3:0]    arg;
    logic [47:0]   lanes;
    int            cmd_cyc;
    int            done_at;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_rom(input logic [IW-1:0] w0, input logic [IW-1:0] w1,
                          input logic [IW-1:0] w2, input logic [IW-1:0] w3);
    for (int a = 0; a < 64; a++) rom[a] = LOOP_WORD;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  task automatic start_run(input logic [TW-1:0] iters);
    bus.NUM_ITERATIONS = iters;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  // Cycle 1 is the FETCH cycle right after START was taken
  task automatic observe(input int max_cyc);
    f_rd_cyc = 0; f_sh_cyc = 0; done_cyc = 0; done_cnt = 0;
    rd_hs = 0; sh_hs = 0; both_cnt = 0;
    f_rd_mask = '0; f_sh_amt = '0; f_sh_lanes = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (bus.RD_VALID && f_rd_cyc == 0) begin f_rd_cyc = c; f_rd_mask = bus.RD_MASK; end
      if (bus.SH_VALID && f_sh_cyc == 0) begin
        f_sh_cyc = c; f_sh_amt = bus.SH_AMOUNT; f_sh_lanes = bus.SH_LANES;
      end
      if (bus.RD_VALID && bus.RD_READY) rd_hs++;
      if (bus.SH_VALID && bus.SH_READY) sh_hs++;
      if (bus.RD_VALID && bus.SH_VALID) both_cnt++;
      if (bus.DONE) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
      if (done_cyc != 0 && c >= done_cyc + 8) break;
      tick();
    end
  endtask

  initial begin
    int          to;
    logic        bad, wrap_seen, swapped;
    logic [AW:0] prev_fetch;

    vecs[0] = '{56'h01,              1, 4'h1, 48'h0,   3, 7};
    vecs[1] = '{56'h0A,              1, 4'hA, 48'h0,   3, 7};
    vecs[2] = '{56'hFFFFFFFFFFFF0C,  1, 4'hC, 48'h0,   3, 7};
    vecs[3] = '{56'h8D15F,           2, 4'hF, 48'h8D1, 3, 7};
    vecs[4] = '{56'hFFFFFFFFFFFF50,  2, 4'h0, 48'hFFFFFFFFFFFF, 3, 7};
    vecs[5] = '{56'h3C,              0, 4'h0, 48'h0,   0, 6};
    vecs[6] = '{56'hABCDF5,          0, 4'h0, 48'h0,   0, 6};
    vecs[7] = '{56'h60,              0, 4'h0, 48'h0,   0, 7};
    vecs[8] = '{56'h70,              0, 4'h0, 48'h0,   0, 4};

    RESET = 1'b1;
    bus.START = 1'b0; bus.NUM_ITERATIONS = '0;
    bus.RD_READY = 1'b1; bus.SH_READY = 1'b1; bus.COMPUTE_DONE = 1'b1;
    load_rom(LOOP_WORD, LOOP_WORD, LOOP_WORD, LOOP_WORD);
    #3;
    check("reset_ctrl", 64'({bus.ROM_ENABLE, bus.ROM_ADDRESS, bus.RD_VALID, bus.RD_MASK,
                             bus.SH_VALID, bus.SH_AMOUNT, bus.BUSY, bus.DONE, bus.ITER_COUNT}), 64'h0);
    check("reset_lanes", 64'(bus.SH_LANES), 64'h0);
    tick();
    RESET = 1'b0;
    tick();

    // Single-instruction programs [inst, LOOP], one pass
    for (int i = 0; i < 9; i++) begin
      load_rom(vecs[i].inst, LOOP_WORD, LOOP_WORD, LOOP_WORD);
      start_run(16'd1);
      observe(40);
      check($sformatf("v%0d_rd_cyc", i), 64'(f_rd_cyc), 64'(vecs[i].kind == 1 ? vecs[i].cmd_cyc : 0));
      check($sformatf("v%0d_sh_cyc", i), 64'(f_sh_cyc), 64'(vecs[i].kind == 2 ? vecs[i].cmd_cyc : 0));
      if (vecs[i].kind == 1) check($sformatf("v%0d_mask", i), 64'(f_rd_mask), 64'(vecs[i].arg));
      if (vecs[i].kind == 2) begin
        check($sformatf("v%0d_amt", i), 64'(f_sh_amt), 64'(vecs[i].arg));
        check($sformatf("v%0d_lanes", i), 64'(f_sh_lanes), 64'(vecs[i].lanes));
      end
      check($sformatf("v%0d_done_cyc", i), 64'(done_cyc), 64'(vecs[i].done_at));
      check($sformatf("v%0d_done_cnt", i), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d_end", i), 64'({bus.BUSY, bus.ITER_COUNT}), 64'h1);
    end

    // Four-instruction program, two passes: 12 cycles per pass
    load_rom(56'h01, 56'h8D15F, 56'h60, LOOP_WORD);
    start_run(16'd2);
    observe(80);
    check("prog_rd_cyc", 64'(f_rd_cyc), 64'd3);
    check("prog_rd_mask", 64'(f_rd_mask), 64'h1);
    check("prog_sh_cyc", 64'(f_sh_cyc), 64'd6);
    check("prog_sh_amt", 64'(f_sh_amt), 64'hF);
    check("prog_sh_lanes", 64'(f_sh_lanes), 64'h8D1);
    check("prog_hs", 64'({8'(rd_hs), 8'(sh_hs)}), 64'h0202);
    check("prog_both", 64'(both_cnt), 64'd0);
    check("prog_done_cyc", 64'(done_cyc), 64'd25);
    check("prog_done_cnt", 64'(done_cnt), 64'd1);
    check("prog_end", 64'({bus.BUSY, bus.ITER_COUNT}), 64'h2);

    // Read backpressure: five cycles of RD_READY low
    load_rom(56'h05, LOOP_WORD, LOOP_WORD, LOOP_WORD);
    bus.RD_READY = 1'b0;
    start_run(16'd1);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_rd_%0d", k), 64'({bus.RD_VALID, bus.RD_MASK}), 64'h15);
      check($sformatf("bp_rom_%0d", k), 64'({bus.ROM_ENABLE, bus.ROM_ADDRESS}), 64'h0);
      tick();
    end
    bus.RD_READY = 1'b1;
    tick();
    check("bp_release", 64'({bus.RD_VALID, bus.ROM_ENABLE, bus.ROM_ADDRESS}), 64'h41);
    observe(20);
    check("bp_done_cnt", 64'(done_cnt), 64'd1);

    // WFI stall: ten cycles of COMPUTE_DONE low
    load_rom(56'h60, 56'h03, LOOP_WORD, LOOP_WORD);
    bus.COMPUTE_DONE = 1'b0;
    start_run(16'd1);
    tick(); tick();
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bad = bad | bus.ROM_ENABLE | bus.RD_VALID | bus.SH_VALID | !bus.BUSY;
      tick();
    end
    check("wfi_stall_quiet", 64'(bad), 64'd0);
    bus.COMPUTE_DONE = 1'b1;
    tick();
    check("wfi_next_fetch", 64'({bus.ROM_ENABLE, bus.ROM_ADDRESS}), 64'h41);
    observe(20);
    check("wfi_rd_mask", 64'(f_rd_mask), 64'h3);
    check("wfi_done_cnt", 64'(done_cnt), 64'd1);

    // NUM_ITERATIONS of zero runs exactly one pass
    load_rom(56'h01, LOOP_WORD, LOOP_WORD, LOOP_WORD);
    start_run(16'd0);
    observe(40);
    check("zero_done_cyc", 64'(done_cyc), 64'd7);
    check("zero_done_cnt", 64'(done_cnt), 64'd1);
    check("zero_iter", 64'(bus.ITER_COUNT), 64'd1);

    // Asynchronous reset while SH_VALID is high in the second pass
    load_rom(56'h8D15F, LOOP_WORD, LOOP_WORD, LOOP_WORD);
    start_run(16'd3);
    to = 0;
    while (bus.ITER_COUNT != 16'd1 && to < 100) begin tick(); to++; end
    bus.SH_READY = 1'b0;
    while (!bus.SH_VALID && to < 100) begin tick(); to++; end
    check("rst_reached_shift", 64'({bus.SH_VALID, bus.ITER_COUNT}), 64'h10001);
    #2 RESET = 1'b1;
    #1;
    check("rst_async_outs", 64'({bus.SH_VALID, bus.BUSY, bus.ITER_COUNT}), 64'h0);
    tick();
    RESET = 1'b0;
    bus.SH_READY = 1'b1;
    tick();
    start_run(16'd1);
    check("rst_restart_fetch", 64'({bus.ROM_ENABLE, bus.ROM_ADDRESS}), 64'h40);
    observe(20);
    check("rst_restart_sh", 64'(f_sh_cyc), 64'd3);
    check("rst_restart_end", 64'({bus.BUSY, bus.ITER_COUNT}), 64'h1);

    // Full-depth ROM: READ at 0, NOPs to 63, wrap back to 0 which now holds the default LOOP
    for (int a = 0; a < 64; a++) rom[a] = NOP_WORD;
    rom[0] = 56'h09;
    start_run(16'd1);
    wrap_seen = 1'b0; swapped = 1'b0; prev_fetch = '1;
    done_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.RD_VALID && bus.RD_READY && !swapped) begin rom[0] = LOOP_WORD; swapped = 1'b1; end
      if (bus.ROM_ENABLE) begin
        if (prev_fetch == 7'd63 && bus.ROM_ADDRESS == 6'd0) wrap_seen = 1'b1;
        prev_fetch = {1'b0, bus.ROM_ADDRESS};
      end
      if (bus.DONE) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
      if (done_cyc != 0 && c >= done_cyc + 8) break;
      bus.START = (c == 50);
      bus.NUM_ITERATIONS = (c == 50) ? 16'd5 : 16'd1;
      tick();
    end
    bus.START = 1'b0;
    check("wrap_seen", 64'(wrap_seen), 64'd1);
    check("wrap_done_cyc", 64'(done_cyc), 64'd133);
    check("wrap_done_cnt", 64'(done_cnt), 64'd1);
    check("wrap_end", 64'({bus.BUSY, bus.ITER_COUNT}), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
